demux_1to2_stream: RTL and testbench

- Receive-side counterpart of the 2-to-1 word multiplexer: takes one time-multiplexed data stream and routes each word to one of two output channels.
- Each output channel has a one-entry registered holding slot with a valid/ready handshake, so the upstream source sees backpressure per channel.
- Channel choice comes either from an explicit select line or from an internal round-robin pointer, which reassembles alternating-word streams.
- Per-channel accepted-word counters support bring-up and debug.

---
 rtl/demux_1to2_stream.sv | 120 ++++++++++++
 tb/tb_demux_1to2_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream
// Routes one incoming word stream to two output channels. Each channel owns a
// one-entry registered slot with a valid/ready handshake, so a stalled channel
// only blocks words aimed at it. The target comes from the select line or from
// an internal round-robin pointer that rebuilds alternating-word streams.
// Per-channel counters record how many words each slot has accepted.
module demux_1to2_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    logic       ptr_reg;
    logic       tgt;
    logic       accept;
    logic [1:0] ready_vec;
    logic [1:0] full_vec;
    logic [1:0] drain_vec;
    logic [1:0] load_vec;

    assign ready_vec = {out1_ready, out0_ready};

    // The round-robin pointer only matters in auto mode; select wins otherwise.
    assign tgt = auto_mode ? ptr_reg : select;

    // A slot can take a new word when it is empty or is being emptied this
    // cycle, which allows a same-cycle pass-through on a full, draining slot.
    assign in_ready = ~full_vec[tgt] | drain_vec[tgt];
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            slot_state_t      state_reg;
            slot_state_t      state_next;
            logic [WIDTH-1:0] data_reg;
            logic [CNT_W-1:0] cnt_reg;

            assign full_vec[gi]  = (state_reg == SLOT_FULL);
            assign drain_vec[gi] = full_vec[gi] & ready_vec[gi];
            assign load_vec[gi]  = accept & (tgt == 1'(gi));

            // Slot occupancy: fill on load, empty on a drain that is not refilled.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    SLOT_EMPTY: if (load_vec[gi]) state_next = SLOT_FULL;
                    SLOT_FULL:  if (drain_vec[gi] && !load_vec[gi]) state_next = SLOT_EMPTY;
                    default:    state_next = SLOT_EMPTY;
                endcase
            end

            // Occupancy register; reset discards any pending word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= SLOT_EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Data is captured only on load and held after a drain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (load_vec[gi]) begin
                    data_reg <= in_data;
                end
            end

            // Accepted-word counter, wrapping naturally at its width.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (load_vec[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Pointer restarts at channel 0 whenever auto mode is off and steps per accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (!auto_mode) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= ~ptr_reg;
        end
    end

    assign out0       = gen_ch[0].data_reg;
    assign out1       = gen_ch[1].data_reg;
    assign out0_valid = full_vec[0];
    assign out1_valid = full_vec[1];
    assign cnt0       = gen_ch[0].cnt_reg;
    assign cnt1       = gen_ch[1].cnt_reg;

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed testbench for demux_1to2_stream (CNT_W=2 so counter wrap is reachable).
module tb_demux_1to2_stream;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             select;
    logic             auto_mode;
    logic [WIDTH-1:0] out0;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;

    demux_1to2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .auto_mode  (auto_mode),
        .out0       (out0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0; select = 1'b0;
        auto_mode = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        #1;
        chk("reset_in_ready", {7'd0, in_ready}, 8'd1);
        chk("reset_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("reset_cnt0", {6'd0, cnt0}, 8'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Single word to channel 1, then drained.
        $display("txn: single word A -> ch1");
        select = 1'b1; in_data = 4'hA; in_valid = 1'b1; out1_ready = 1'b1;
        chk("t1_in_ready", {7'd0, in_ready}, 8'd1);
        step();
        in_valid = 1'b0;
        chk("t1_out1", {4'd0, out1}, 8'hA);
        chk("t1_out1_valid", {7'd0, out1_valid}, 8'd1);
        chk("t1_cnt1", {6'd0, cnt1}, 8'd1);
        chk("t1_out0_valid", {7'd0, out0_valid}, 8'd0);
        step();
        chk("t1_out1_valid_drained", {7'd0, out1_valid}, 8'd0);
        chk("t1_out1_held", {4'd0, out1}, 8'hA);

        // Backpressure on channel 0, then pass-through.
        $display("txn: backpressure 3,5 -> ch0");
        out1_ready = 1'b0; out0_ready = 1'b0; select = 1'b0;
        in_data = 4'h3; in_valid = 1'b1;
        step();
        in_data = 4'h5;
        chk("t2_in_ready_blocked", {7'd0, in_ready}, 8'd0);
        step();
        chk("t2_out0_held", {4'd0, out0}, 8'h3);
        chk("t2_cnt0_stalled", {6'd0, cnt0}, 8'd1);
        out0_ready = 1'b1;
        #1;
        chk("t2_in_ready_pass", {7'd0, in_ready}, 8'd1);
        step();
        chk("t2_out0_pass", {4'd0, out0}, 8'h5);
        chk("t2_out0_valid", {7'd0, out0_valid}, 8'd1);
        chk("t2_cnt0", {6'd0, cnt0}, 8'd2);

        // Channel 0 stalled full; a word for channel 1 still goes through.
        $display("txn: cross-channel 7 -> ch1 while ch0 stalled");
        out0_ready = 1'b0; select = 1'b1; in_data = 4'h7;
        #1;
        chk("t3_in_ready", {7'd0, in_ready}, 8'd1);
        step();
        in_valid = 1'b0;
        chk("t3_out1", {4'd0, out1}, 8'h7);
        chk("t3_out1_valid", {7'd0, out1_valid}, 8'd1);
        chk("t3_out0_unchanged", {4'd0, out0}, 8'h5);
        chk("t3_out0_valid", {7'd0, out0_valid}, 8'd1);
        chk("t3_cnt0", {6'd0, cnt0}, 8'd2);
        chk("t3_cnt1", {6'd0, cnt1}, 8'd2);

        // Round-robin reassembly.
        do_reset();
        $display("txn: round-robin 1,2,3,4,5 then auto drop, 6");
        auto_mode = 1'b1; out0_ready = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
        in_data = 4'h1; step();
        chk("t4_w1_out0", {4'd0, out0}, 8'h1);
        in_data = 4'h2; step();
        chk("t4_w2_out1", {4'd0, out1}, 8'h2);
        in_data = 4'h3; step();
        chk("t4_w3_out0", {4'd0, out0}, 8'h3);
        in_data = 4'h4; step();
        chk("t4_w4_out1", {4'd0, out1}, 8'h4);
        chk("t4_cnt0", {6'd0, cnt0}, 8'd2);
        chk("t4_cnt1", {6'd0, cnt1}, 8'd2);
        in_data = 4'h5; step();
        chk("t4_w5_out0", {4'd0, out0}, 8'h5);
        in_valid = 1'b0; auto_mode = 1'b0; step();
        auto_mode = 1'b1; in_valid = 1'b1; in_data = 4'h6; step();
        in_valid = 1'b0;
        chk("t4_w6_out0", {4'd0, out0}, 8'h6);
        chk("t4_w6_out0_valid", {7'd0, out0_valid}, 8'd1);
        chk("t4_w6_out1_valid", {7'd0, out1_valid}, 8'd0);
        chk("t4_cnt0_wrap", {6'd0, cnt0}, 8'd0);

        // Counter wrap with five words to channel 1.
        do_reset();
        $display("txn: 5 words -> ch1, counter wrap");
        auto_mode = 1'b0; select = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 4'(i + 8);
            step();
            chk($sformatf("t5_cnt1_%0d", i), {6'd0, cnt1}, 8'((i + 1) % 4));
            chk($sformatf("t5_out1_%0d", i), {4'd0, out1}, 8'(i + 8));
        end
        in_valid = 1'b0;

        // Mid-cycle asynchronous reset with both slots full and ptr=1.
        do_reset();
        $display("txn: async reset with both slots full");
        auto_mode = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
        in_data = 4'h9; step();
        in_data = 4'hC; step();
        in_data = 4'hD; out0_ready = 1'b1; step();
        out0_ready = 1'b0; in_valid = 1'b0;
        chk("t6_pre_out0", {4'd0, out0}, 8'hD);
        chk("t6_pre_both_valid", {6'd0, out1_valid, out0_valid}, 8'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valids", {6'd0, out1_valid, out0_valid}, 8'd0);
        chk("t6_rst_data", {out1, out0}, 8'h00);
        chk("t6_rst_cnts", {4'd0, cnt1, cnt0}, 8'd0);
        chk("t6_rst_in_ready", {7'd0, in_ready}, 8'd1);
        step();
        rst = 1'b0;
        step();
        out0_ready = 1'b1; out1_ready = 1'b1; in_valid = 1'b1; in_data = 4'hE;
        step();
        in_valid = 1'b0;
        chk("t6_ptr_reset_out0", {4'd0, out0}, 8'hE);
        chk("t6_ptr_reset_out1_valid", {7'd0, out1_valid}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
